// File: rtl/slot_game_ctrl.sv
// Slot-machine game controller: command FSM, LFSR-driven reels, bet/payout/jackpot accounting, leaderboard save.
// Optional build macro SLOT_PAIR_PAY_EN adds adjacent-pair payouts (win_code 01).
module slot_game_ctrl #(
   parameter int NUM_REELS    = 3,
   parameter int REEL_W       = 4,
   parameter int SCORE_W      = 17,
   parameter int START_COINS  = 100,
   parameter int MIN_BET      = 1,
   parameter int MAX_BET      = 5,
   parameter int MIN_PAYOUT   = 200,
   parameter int MAX_PAYOUT   = 1000,
   parameter int JACKPOT_INIT = 10000
) (
   input  logic                          CLOCK_50,
   input  logic                          reset,
   input  logic                          enter,
   input  logic                          play,
   input  logic                          bet_max,
   input  logic                          stop,
   input  logic                          spin_again,
   input  logic                          escape,
   input  logic                          save_ack,
   output logic [5:0]                    state,
   output logic [NUM_REELS*REEL_W-1:0]   reels,
   output logic [SCORE_W-1:0]            score,
   output logic [SCORE_W-1:0]            jackpot,
   output logic [1:0]                    win_code,
   output logic                          no_funds,
   output logic                          save_req,
   output logic [SCORE_W-1:0]            save_score
);

   typedef enum logic [5:0] {
      S_START = 6'b000001,
      S_LOAD  = 6'b000010,
      S_PLAY  = 6'b000100,
      S_SPIN  = 6'b001000,
      S_WIN   = 6'b010000,
      S_RESET = 6'b100000
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   state_t                        state_q, state_d;
   logic [15:0]                   lfsr_q, lfsr_d;
   logic [NUM_REELS*REEL_W-1:0]   reels_q, reels_d;
   logic [NUM_REELS-1:0]          running_q, running_d;
   logic [SCORE_W-1:0]            score_q, score_d;
   logic [SCORE_W-1:0]            jackpot_q, jackpot_d;
   logic [1:0]                    win_code_q, win_code_d;
   logic                          no_funds_q, no_funds_d;
   logic                          bet_max_q, bet_max_d;
   logic                          eval_q, eval_d;

   logic [SCORE_W-1:0]            bet_amt;
   logic                          all_eq;
   logic                          all_ones;
   logic                          stop_found;

   function automatic logic [REEL_W-1:0] lfsr_slice(input logic [15:0] v, input int reel_idx);
      logic [REEL_W-1:0] s;
      logic [3:0]        pos;
      s = '0;
      for (int b = 0; b < REEL_W; b++) begin
         pos  = 4'((reel_idx * REEL_W + b) % 16);
         s[b] = v[pos];
      end
      return s;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

   // Bet size for a new play comes from the live bet_max level.
   assign bet_amt = bet_max ? SCORE_W'(MAX_BET) : SCORE_W'(MIN_BET);

   always_comb begin
      all_eq = 1'b1;
      for (int i = 1; i < NUM_REELS; i++) begin
         if (reels_q[i*REEL_W +: REEL_W] != reels_q[0 +: REEL_W]) all_eq = 1'b0;
      end
      all_ones = &reels_q[0 +: REEL_W];
   end

`ifdef SLOT_PAIR_PAY_EN
   logic                          pair_hit;
   logic [SCORE_W-1:0]            pair_pay;

   always_comb begin
      pair_hit = 1'b0;
      for (int i = 0; i < NUM_REELS - 1; i++) begin
         if (reels_q[i*REEL_W +: REEL_W] == reels_q[(i+1)*REEL_W +: REEL_W]) pair_hit = 1'b1;
      end
   end

   assign pair_pay = bet_max_q ? SCORE_W'(2 * MAX_BET) : SCORE_W'(2 * MIN_BET);
`endif

   always_comb begin
      state_d    = state_q;
      lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      reels_d    = reels_q;
      running_d  = running_q;
      score_d    = score_q;
      jackpot_d  = jackpot_q;
      win_code_d = win_code_q;
      no_funds_d = 1'b0;
      bet_max_d  = bet_max_q;
      eval_d     = 1'b0;
      stop_found = 1'b0;

      case (state_q)
         S_START: begin
            if (enter) begin
               state_d = S_LOAD;
               score_d = SCORE_W'(START_COINS);
            end
         end

         S_LOAD: begin
            if (enter) state_d = S_PLAY;
         end

         S_PLAY: begin
            if (escape) begin
               state_d = S_RESET;
            end else if (play) begin
               if (score_q >= bet_amt) begin
                  score_d   = score_q - bet_amt;
                  jackpot_d = sat_add(jackpot_q, bet_amt);
                  bet_max_d = bet_max;
                  running_d = '1;
                  state_d   = S_SPIN;
               end else begin
                  no_funds_d = 1'b1;
               end
            end
         end

         S_SPIN: begin
            for (int i = 0; i < NUM_REELS; i++) begin
               if (running_q[i]) reels_d[i*REEL_W +: REEL_W] = lfsr_slice(lfsr_q, i);
            end
            // A stop captures the current symbol into the lowest running reel and freezes it.
            if (stop) begin
               for (int i = 0; i < NUM_REELS; i++) begin
                  if (running_q[i] && !stop_found) begin
                     running_d[i] = 1'b0;
                     stop_found   = 1'b1;
                  end
               end
               if (running_d == '0) begin
                  state_d = S_WIN;
                  eval_d  = 1'b1;
               end
            end
         end

         S_WIN: begin
            // First WIN cycle is reserved for scoring; commands are acted on from the next cycle.
            if (eval_q) begin
               if (all_eq && all_ones) begin
                  score_d    = sat_add(score_q, jackpot_q);
                  jackpot_d  = SCORE_W'(JACKPOT_INIT);
                  win_code_d = 2'b11;
               end else if (all_eq) begin
                  score_d    = sat_add(score_q, bet_max_q ? SCORE_W'(MAX_PAYOUT) : SCORE_W'(MIN_PAYOUT));
                  win_code_d = 2'b10;
               end
`ifdef SLOT_PAIR_PAY_EN
               else if (pair_hit) begin
                  score_d    = sat_add(score_q, pair_pay);
                  win_code_d = 2'b01;
               end
`endif
               else begin
                  win_code_d = 2'b00;
               end
            end else if (escape) begin
               state_d    = S_RESET;
               win_code_d = 2'b00;
            end else if (spin_again) begin
               state_d    = (score_q != '0) ? S_PLAY : S_RESET;
               win_code_d = 2'b00;
            end
         end

         // save_req/save_ack: save_req is held high with save_score stable for every cycle of
         // this state; a transfer completes on any cycle where both are high, and save_ack
         // seen while save_req is low has no effect.
         S_RESET: begin
            if (save_ack) begin
               state_d = S_START;
               score_d = '0;
            end
         end

         default: begin
            state_d = S_START;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= S_START;
         lfsr_q     <= LFSR_SEED;
         reels_q    <= '0;
         running_q  <= '0;
         score_q    <= '0;
         jackpot_q  <= SCORE_W'(JACKPOT_INIT);
         win_code_q <= 2'b00;
         no_funds_q <= 1'b0;
         bet_max_q  <= 1'b0;
         eval_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         reels_q    <= reels_d;
         running_q  <= running_d;
         score_q    <= score_d;
         jackpot_q  <= jackpot_d;
         win_code_q <= win_code_d;
         no_funds_q <= no_funds_d;
         bet_max_q  <= bet_max_d;
         eval_q     <= eval_d;
      end
   end

   assign state      = state_q;
   assign reels      = reels_q;
   assign score      = score_q;
   assign jackpot    = jackpot_q;
   assign win_code   = win_code_q;
   assign no_funds   = no_funds_q;
   assign save_req   = (state_q == S_RESET);
   assign save_score = score_q;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Bench for slot_game_ctrl: command vector table, steered and random spins scored by a game model.
module tb_slot_game_ctrl;

   localparam int SW = 17;
   localparam int SCORE_MAX = 131071;
   localparam logic [5:0] ST_START = 6'b000001;
   localparam logic [5:0] ST_LOAD  = 6'b000010;
   localparam logic [5:0] ST_PLAY  = 6'b000100;
   localparam logic [5:0] ST_SPIN  = 6'b001000;
   localparam logic [5:0] ST_WIN   = 6'b010000;
   localparam logic [5:0] ST_RESET = 6'b100000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enter = 1'b0, play = 1'b0, bet_max = 1'b0, stop = 1'b0;
   logic          spin_again = 1'b0, escape = 1'b0, save_ack = 1'b0;
   logic [5:0]    state;
   logic [11:0]   reels;
   logic [SW-1:0] score, jackpot, save_score;
   logic [1:0]    win_code;
   logic          no_funds, save_req;

   always #5 clk = ~clk;

   slot_game_ctrl dut (
      .CLOCK_50  (clk),
      .reset     (reset),
      .enter     (enter),
      .play      (play),
      .bet_max   (bet_max),
      .stop      (stop),
      .spin_again(spin_again),
      .escape    (escape),
      .save_ack  (save_ack),
      .state     (state),
      .reels     (reels),
      .score     (score),
      .jackpot   (jackpot),
      .win_code  (win_code),
      .no_funds  (no_funds),
      .save_req  (save_req),
      .save_score(save_score)
   );

   typedef struct {
      logic       enter, play, bet_max, stop, spin_again, escape, save_ack;
      logic [5:0] exp_state;
      int         exp_score;
      int         exp_jackpot;
      logic       exp_nf;
   } vec_t;

   vec_t        vecs[12];
   int          n_checks = 0;
   int          n_err    = 0;
   logic [15:0] m_lfsr   = 16'hACE1;
   int          m_score  = 0;
   int          m_jackpot = 10000;
   logic        m_bm     = 1'b0;

   task automatic report_and_finish();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      // Taps 16,14,13,11 counted from 1 at the LSB end.
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [3:0] reel_sym(input logic [15:0] v, input int k);
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = v[(k * 4 + b) % 16];
      return r;
   endfunction

   function automatic int sat(input int v);
      return (v > SCORE_MAX) ? SCORE_MAX : v;
   endfunction

   // One clock; m_lfsr always holds the register value the next edge will see.
   task automatic tick();
      logic r;
      r = reset;
      @(posedge clk);
      m_lfsr = r ? 16'hACE1 : lfsr_step(m_lfsr);
      #1;
   endtask

   task automatic do_enter(input logic [5:0] exp_state);
      enter = 1'b1;
      tick();
      enter = 1'b0;
      check("enter_state", 32'(state), 32'(exp_state));
      check("enter_score", 32'(score), 32'(m_score));
   endtask

   task automatic do_play(input logic bm);
      int   bet;
      logic ok;
      bet = bm ? 5 : 1;
      ok  = (m_score >= bet);
      bet_max = bm;
      play    = 1'b1;
      tick();
      play = 1'b0;
      if (ok) begin
         m_score   = m_score - bet;
         m_jackpot = sat(m_jackpot + bet);
         m_bm      = bm;
         check("play_state", 32'(state), 32'(ST_SPIN));
         check("play_no_funds", 32'(no_funds), 32'd0);
      end else begin
         check("play_rej_state", 32'(state), 32'(ST_PLAY));
         check("play_no_funds", 32'(no_funds), 32'd1);
      end
      check("play_score", 32'(score), 32'(m_score));
      check("play_jackpot", 32'(jackpot), 32'(m_jackpot));
   endtask

   task automatic do_spin_again();
      spin_again = 1'b1;
      tick();
      spin_again = 1'b0;
      check("again_state", 32'(state), 32'((m_score != 0) ? ST_PLAY : ST_RESET));
      check("again_win_code", 32'(win_code), 32'd0);
   endtask

   // mode 0: every reel lands on sym; 1: all reels differ; 2: random stop timing with command noise.
   task automatic spin(input int mode, input logic [3:0] sym);
      logic [3:0] f[3];
      logic [3:0] s;
      logic       ok;
      int         waited, target, exp_wc;
      for (int k = 0; k < 3; k++) begin
         waited = 0;
         target = $urandom_range(0, 3);
         while (1) begin
            s = reel_sym(m_lfsr, k);
            case (mode)
               0:       ok = (s == sym);
               1:       ok = (k == 0) || (k == 1 && s != f[0]) || (k == 2 && s != f[0] && s != f[1]);
               default: ok = (waited >= target);
            endcase
            if (ok) break;
            if (waited >= 3000) begin
               n_checks++;
               n_err++;
               $display("FAIL spin_timeout: reel %0d never reached its stop condition", k);
               report_and_finish();
            end
            if (mode == 2) begin
               enter  = 1'($urandom_range(0, 1));
               play   = 1'($urandom_range(0, 1));
               escape = 1'($urandom_range(0, 1));
            end
            tick();
            enter  = 1'b0;
            play   = 1'b0;
            escape = 1'b0;
            waited++;
         end
         stop = 1'b1;
         f[k] = reel_sym(m_lfsr, k);
         tick();
         stop = 1'b0;
         if (k < 2) check("spin_state", 32'(state), 32'(ST_SPIN));
      end
      check("win_entry_state", 32'(state), 32'(ST_WIN));
      check("win_reels", 32'(reels), 32'({f[2], f[1], f[0]}));
      check("win_entry_score", 32'(score), 32'(m_score));

      exp_wc = 0;
      if (f[0] == f[1] && f[1] == f[2] && f[0] == 4'hF) begin
         m_score   = sat(m_score + m_jackpot);
         m_jackpot = 10000;
         exp_wc    = 3;
      end else if (f[0] == f[1] && f[1] == f[2]) begin
         m_score = sat(m_score + (m_bm ? 1000 : 200));
         exp_wc  = 2;
      end
`ifdef SLOT_PAIR_PAY_EN
      else if (f[0] == f[1] || f[1] == f[2]) begin
         m_score = sat(m_score + 2 * (m_bm ? 5 : 1));
         exp_wc  = 1;
      end
`endif
      tick();
      check("win_score", 32'(score), 32'(m_score));
      check("win_jackpot", 32'(jackpot), 32'(m_jackpot));
      check("win_code", 32'(win_code), 32'(exp_wc));
      tick();
      check("win_hold_state", 32'(state), 32'(ST_WIN));
      check("win_reels_frozen", 32'(reels), 32'({f[2], f[1], f[0]}));
   endtask

   task automatic drain(input int target);
      int guard;
      guard = 0;
      while (m_score > target && guard < 200) begin
         do_play(m_score - 5 >= target);
         spin(1, 4'h0);
         do_spin_again();
         guard++;
      end
      check("drain_score", 32'(score), 32'(target));
   endtask

   task automatic hard_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_score   = 0;
      m_jackpot = 10000;
   endtask

   initial begin
      #500000;
      n_checks++;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      report_and_finish();
   end

   initial begin
      //             en  pl  bm  st  sa  es  ack  state     score jackpot nf
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, ST_START, 0,   10000, 1'b0};
      vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, ST_START, 0,   10000, 1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ST_START, 0,   10000, 1'b0};
      vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ST_LOAD,  100, 10000, 1'b0};
      vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, ST_LOAD,  100, 10000, 1'b0};
      vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ST_PLAY,  100, 10000, 1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, ST_PLAY,  100, 10000, 1'b0};
      vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ST_PLAY,  100, 10000, 1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, ST_PLAY,  100, 10000, 1'b0};
      vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, ST_SPIN,  95,  10005, 1'b0};
      vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, ST_SPIN,  95,  10005, 1'b0};
      vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, ST_SPIN,  95,  10005, 1'b0};

      tick();
      tick();
      check("rst_state", 32'(state), 32'(ST_START));
      check("rst_reels", 32'(reels), 32'd0);
      check("rst_score", 32'(score), 32'd0);
      check("rst_jackpot", 32'(jackpot), 32'd10000);
      check("rst_win_code", 32'(win_code), 32'd0);
      check("rst_no_funds", 32'(no_funds), 32'd0);
      check("rst_save_req", 32'(save_req), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         enter      = vecs[i].enter;
         play       = vecs[i].play;
         bet_max    = vecs[i].bet_max;
         stop       = vecs[i].stop;
         spin_again = vecs[i].spin_again;
         escape     = vecs[i].escape;
         save_ack   = vecs[i].save_ack;
         tick();
         {enter, play, stop, spin_again, escape, save_ack} = '0;
         check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
         check($sformatf("vec%0d_score", i), 32'(score), 32'(vecs[i].exp_score));
         check($sformatf("vec%0d_jackpot", i), 32'(jackpot), 32'(vecs[i].exp_jackpot));
         check($sformatf("vec%0d_no_funds", i), 32'(no_funds), 32'(vecs[i].exp_nf));
      end
      m_score   = 95;
      m_jackpot = 10005;
      m_bm      = 1'b1;

      // Full match of 5s on a max bet.
      spin(0, 4'h5);
      check("match5_score", 32'(score), 32'd1095);
      check("match5_code", 32'(win_code), 32'd2);

      // Reset in WIN restores the jackpot pool; then hit the jackpot from a fresh session.
      hard_reset();
      check("mid_rst_state", 32'(state), 32'(ST_START));
      check("mid_rst_jackpot", 32'(jackpot), 32'd10000);
      check("mid_rst_reels", 32'(reels), 32'd0);
      m_score = 100;
      do_enter(ST_LOAD);
      do_enter(ST_PLAY);
      do_play(1'b1);
      spin(0, 4'hF);
      check("jackpot_score", 32'(score), 32'd10100);
      check("jackpot_pool", 32'(jackpot), 32'd10000);
      check("jackpot_code", 32'(win_code), 32'd3);

      for (int n = 0; n < 30; n++) begin
         do_spin_again();
         do_play(1'($urandom_range(0, 1)));
         spin(2, 4'h0);
      end

      escape = 1'b1;
      tick();
      escape = 1'b0;
      check("esc_win_state", 32'(state), 32'(ST_RESET));
      check("esc_save_req", 32'(save_req), 32'd1);
      check("esc_save_score", 32'(save_score), 32'(m_score));
      save_ack = 1'b1;
      tick();
      save_ack = 1'b0;
      m_score = 0;
      check("ack_state", 32'(state), 32'(ST_START));
      check("ack_score", 32'(score), 32'd0);
      check("ack_save_req", 32'(save_req), 32'd0);

      // Insufficient credit, then escape beating a same-cycle play.
      m_score = 100;
      do_enter(ST_LOAD);
      do_enter(ST_PLAY);
      drain(3);
      do_play(1'b1);
      tick();
      check("nf_pulse_end", 32'(no_funds), 32'd0);
      check("nf_state", 32'(state), 32'(ST_PLAY));
      escape  = 1'b1;
      play    = 1'b1;
      bet_max = 1'b0;
      tick();
      escape = 1'b0;
      play   = 1'b0;
      check("esc_play_state", 32'(state), 32'(ST_RESET));
      check("esc_play_score", 32'(score), 32'd3);
      check("esc_play_save_score", 32'(save_score), 32'd3);
      tick();
      check("save_hold_req", 32'(save_req), 32'd1);
      check("save_hold_state", 32'(state), 32'(ST_RESET));
      save_ack = 1'b1;
      tick();
      save_ack = 1'b0;
      m_score = 0;
      check("save3_state", 32'(state), 32'(ST_START));
      check("save3_score", 32'(score), 32'd0);

      // Broke in WIN: spin_again goes to RESET; a reset there drops the pending save.
      m_score = 100;
      do_enter(ST_LOAD);
      do_enter(ST_PLAY);
      drain(1);
      do_play(1'b0);
      spin(1, 4'h0);
      check("broke_score", 32'(score), 32'd0);
      do_spin_again();
      check("broke_save_req", 32'(save_req), 32'd1);
      check("broke_save_score", 32'(save_score), 32'd0);
      hard_reset();
      check("rst_in_reset_state", 32'(state), 32'(ST_START));
      check("rst_in_reset_req", 32'(save_req), 32'd0);

      report_and_finish();
   end

endmodule
